hazard_ctrl: RTL and testbench
==============================

// Module: hazard_ctrl
// PURPOSE
//  Pipeline sequencing controller for the 5-stage RV32I core: keeps shadow rd/rs/valid tags for EX, MEM, WB.
//  Generates PC/IF-ID/ID-EX enables, flushes and bubbles for load-use, multicycle MUL and taken-branch events.
//  Drives EX operand forward selects so the ID_EXE datapath reads register file or MEM/WB results correctly.
//  Register file is write-before-read internally, so no ID-stage bypass is generated here.
// PARAMETERS
//  REG_AW   5  register address width
//  MUL_LAT  4  cycles a MUL occupies EX (>=1; 1 = no stall)
// PORTS
//  clk             in   1      clock, all state on rising edge
//  rst             in   1      asynchronous, active-low reset
//  id_valid        in   1      IF/ID holds a valid instruction
//  id_rs1,id_rs2   in   REG_AW source regs of ID instruction
//  id_rs1_used     in   1      ID instruction reads rs1
//  id_rs2_used     in   1      ID instruction reads rs2
//  id_rd           in   REG_AW dest reg of ID instruction
//  id_wb_en        in   1      ID instruction writes rd
//  id_is_load      in   1      ID instruction is a load
//  id_is_mul       in   1      ID instruction is a multicycle MUL
//  ex_branch_taken in   1      EX resolves taken branch/jump (ignored unless EX valid and not busy)
//  pc_en           out  1      PC may update
//  ifid_en         out  1      IF/ID register may load
//  ifid_flush      out  1      IF/ID loads a bubble
//  idex_en         out  1      ID/EX register may load
//  idex_flush      out  1      ID/EX loads a bubble
//  exmem_bubble    out  1      EX/MEM loads a bubble
//  fwd_a_sel       out  2      EX rs1 source: 00 regfile, 01 EX/MEM result, 10 MEM/WB result
//  fwd_b_sel       out  2      EX rs2 source, same encoding
//  ex_busy         out  1      MUL in progress in EX
// BEHAVIOUR
//  State: ex/mem/wb tags {valid,rd,wb_en,is_load}, ex also {rs1,rs2,used bits,is_mul}; mul_cnt.
//  Reset (rst=0, async): all tag valid=0, mul_cnt=0 -> pc_en=ifid_en=idex_en=1, all flush/bubble=0, fwd=00, ex_busy=0.
//  match(s,r): s.valid & s.wb_en & s.rd!=0 & s.rd==r. rd==x0 never stalls or forwards.
//  ex_busy = (mul_cnt!=0).
//  brk = ex_branch_taken & ex.valid & !ex_busy.
//  load_use = id_valid & ex.is_load & ((id_rs1_used & match(ex,id_rs1)) | (id_rs2_used & match(ex,id_rs2))).
//  Outputs, priority order (combinational from state+inputs):
//   1 ex_busy: pc_en=ifid_en=idex_en=0, exmem_bubble=1, flushes=0.
//   2 brk: pc_en=ifid_en=idex_en=1, ifid_flush=1, idex_flush=1 (load_use ignored; wrong path).
//   3 load_use: pc_en=ifid_en=0, idex_en=1, idex_flush=1 (one bubble).
//   4 else: all enables 1, flushes/bubble 0.
//  Forwarding (EX instr): fwd=01 if used & match(mem,rs) & !mem.is_load; else 10 if used & match(wb,rs); else 00.
//   MEM beats WB. Load in MEM matching EX cannot occur (load_use gap); select 00 in that case.
//  Tag update each edge: wb<=mem; mem<= exmem_bubble ? bubble : ex;
//   ex <= ex_busy ? ex (hold) : (idex_flush | !id_valid) ? bubble : ID fields.
//  mul_cnt: load MUL_LAT-1 when a valid MUL enters EX (ex loaded from ID, id_is_mul); else decrement while !=0.
//   MUL occupies EX exactly MUL_LAT cycles, advances to MEM on the cycle mul_cnt==0; consumer forwards via 01.
//  Reset asserted mid-MUL/stall: state cleared immediately, outputs return to reset values.
// TESTING
//  lw x5 then add x6,x5,x1 -> 1 cycle pc_en=ifid_en=0, idex_flush=1; add in EX sees fwd_a_sel=10.
//  add x5 then sub x7,x1,x5 -> no stall; sub in EX sees fwd_b_sel=01; with one nop between -> 10.
//  lw x0 then add x6,x0,x0 -> no stall, fwd 00; add x5 then add x5 then use x5 -> 01 (MEM wins).
//  MUL_LAT=4: mul x5 enters EX -> ex_busy=1 and exmem_bubble=1 for 3 cycles, then dependent add gets fwd=01.
//  Taken branch in EX while ID holds load-dependent instr -> ifid_flush=idex_flush=1, pc_en=1, no stall.
//  rst=0 during 2nd busy MUL cycle -> ex_busy=0, enables=1, fwd=00 at once; pipeline restarts cleanly after release.

Source files
------------

// File: rtl/hazard_ctrl_if.sv
// Interface bundling the ID-stage hazard inputs and the pipeline control /
// operand-forwarding outputs of the hazard controller.
interface hazard_ctrl_if #(
    parameter int REG_AW = 5
);
    logic              id_valid;
    logic [REG_AW-1:0] id_rs1;
    logic [REG_AW-1:0] id_rs2;
    logic              id_rs1_used;
    logic              id_rs2_used;
    logic [REG_AW-1:0] id_rd;
    logic              id_wb_en;
    logic              id_is_load;
    logic              id_is_mul;
    logic              ex_branch_taken;
    logic              pc_en;
    logic              ifid_en;
    logic              ifid_flush;
    logic              idex_en;
    logic              idex_flush;
    logic              exmem_bubble;
    logic [1:0]        fwd_a_sel;
    logic [1:0]        fwd_b_sel;
    logic              ex_busy;

    // Controller side: consumes ID info, produces enables/flushes/forward selects.
    modport slave (
        input  id_valid, id_rs1, id_rs2, id_rs1_used, id_rs2_used,
               id_rd, id_wb_en, id_is_load, id_is_mul, ex_branch_taken,
        output pc_en, ifid_en, ifid_flush, idex_en, idex_flush,
               exmem_bubble, fwd_a_sel, fwd_b_sel, ex_busy
    );

    // Pipeline side: supplies ID info, obeys the control outputs.
    modport master (
        output id_valid, id_rs1, id_rs2, id_rs1_used, id_rs2_used,
               id_rd, id_wb_en, id_is_load, id_is_mul, ex_branch_taken,
        input  pc_en, ifid_en, ifid_flush, idex_en, idex_flush,
               exmem_bubble, fwd_a_sel, fwd_b_sel, ex_busy
    );
endinterface

// File: rtl/hazard_ctrl.sv
// Pipeline sequencing controller for the 5-stage RV32I core. Tracks shadow
// tags of the EX, MEM and WB instructions, resolves load-use, multicycle MUL
// and taken-branch hazards, and selects the EX operand forwarding sources.
module hazard_ctrl #(
    parameter int REG_AW  = 5,
    parameter int MUL_LAT = 4
) (
    input  logic          clk,
    input  logic          rst,
    hazard_ctrl_if.slave  hif
);
    localparam int            CW       = (MUL_LAT > 1) ? $clog2(MUL_LAT) : 1;
    localparam logic [CW-1:0] CNT_ZERO = CW'(0);
    localparam logic [CW-1:0] CNT_ONE  = CW'(1);
    localparam logic [CW-1:0] CNT_LOAD = CW'(MUL_LAT - 1);
    localparam logic [REG_AW-1:0] REG_X0 = {REG_AW{1'b0}};

    // Producer tag writes register r (x0 never counts as a producer).
    function automatic logic tag_match(input logic v, input logic wb,
                                       input logic [REG_AW-1:0] rd,
                                       input logic [REG_AW-1:0] r);
        return v & wb & (rd != REG_X0) & (rd == r);
    endfunction

    // EX tag
    logic              ex_valid_r, ex_wb_en_r, ex_is_load_r;
    logic [REG_AW-1:0] ex_rd_r, ex_rs1_r, ex_rs2_r;
    logic              ex_rs1_used_r, ex_rs2_used_r;
    // MEM tag
    logic              mem_valid_r, mem_wb_en_r, mem_is_load_r;
    logic [REG_AW-1:0] mem_rd_r;
    // WB tag (load-ness no longer matters once data is in WB)
    logic              wb_valid_r, wb_wb_en_r;
    logic [REG_AW-1:0] wb_rd_r;
    // Remaining extra EX cycles of the current MUL
    logic [CW-1:0]     mul_cnt_r;

    logic ex_busy_s, brk_s, load_use_s, mul_enter_s;
    logic pc_en_s, ifid_en_s, ifid_flush_s, idex_en_s, idex_flush_s, exmem_bubble_s;
    logic [1:0] fwd_a_s, fwd_b_s;

    assign ex_busy_s  = (mul_cnt_r != CNT_ZERO);
    assign brk_s      = hif.ex_branch_taken & ex_valid_r & ~ex_busy_s;
    assign load_use_s = hif.id_valid & ex_is_load_r &
                        ((hif.id_rs1_used & tag_match(ex_valid_r, ex_wb_en_r, ex_rd_r, hif.id_rs1)) |
                         (hif.id_rs2_used & tag_match(ex_valid_r, ex_wb_en_r, ex_rd_r, hif.id_rs2)));
    // A MUL starts its count only when it actually enters EX from ID.
    assign mul_enter_s = ~ex_busy_s & ~idex_flush_s & hif.id_valid & hif.id_is_mul;

    // Prioritised stall/flush decision: busy MUL, then taken branch, then load-use.
    always_comb begin
        pc_en_s        = 1'b1;
        ifid_en_s      = 1'b1;
        ifid_flush_s   = 1'b0;
        idex_en_s      = 1'b1;
        idex_flush_s   = 1'b0;
        exmem_bubble_s = 1'b0;
        if (ex_busy_s) begin
            pc_en_s        = 1'b0;
            ifid_en_s      = 1'b0;
            idex_en_s      = 1'b0;
            exmem_bubble_s = 1'b1;
        end else if (brk_s) begin
            ifid_flush_s = 1'b1;
            idex_flush_s = 1'b1;
        end else if (load_use_s) begin
            pc_en_s      = 1'b0;
            ifid_en_s    = 1'b0;
            idex_flush_s = 1'b1;
        end else begin
            pc_en_s = 1'b1;
        end
    end

    // EX rs1 source: MEM result beats WB result; a load in MEM is never a source.
    always_comb begin
        fwd_a_s = 2'b00;
        if (ex_rs1_used_r & tag_match(mem_valid_r, mem_wb_en_r, mem_rd_r, ex_rs1_r)) begin
            fwd_a_s = mem_is_load_r ? 2'b00 : 2'b01;
        end else if (ex_rs1_used_r & tag_match(wb_valid_r, wb_wb_en_r, wb_rd_r, ex_rs1_r)) begin
            fwd_a_s = 2'b10;
        end else begin
            fwd_a_s = 2'b00;
        end
    end

    // EX rs2 source, same rules as rs1.
    always_comb begin
        fwd_b_s = 2'b00;
        if (ex_rs2_used_r & tag_match(mem_valid_r, mem_wb_en_r, mem_rd_r, ex_rs2_r)) begin
            fwd_b_s = mem_is_load_r ? 2'b00 : 2'b01;
        end else if (ex_rs2_used_r & tag_match(wb_valid_r, wb_wb_en_r, wb_rd_r, ex_rs2_r)) begin
            fwd_b_s = 2'b10;
        end else begin
            fwd_b_s = 2'b00;
        end
    end

    // Advance the shadow tags: WB<-MEM, MEM<-EX or bubble, EX<-ID, bubble or hold.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            ex_valid_r    <= 1'b0;
            ex_wb_en_r    <= 1'b0;
            ex_is_load_r  <= 1'b0;
            ex_rd_r       <= REG_X0;
            ex_rs1_r      <= REG_X0;
            ex_rs2_r      <= REG_X0;
            ex_rs1_used_r <= 1'b0;
            ex_rs2_used_r <= 1'b0;
            mem_valid_r   <= 1'b0;
            mem_wb_en_r   <= 1'b0;
            mem_is_load_r <= 1'b0;
            mem_rd_r      <= REG_X0;
            wb_valid_r    <= 1'b0;
            wb_wb_en_r    <= 1'b0;
            wb_rd_r       <= REG_X0;
        end else begin
            wb_valid_r <= mem_valid_r;
            wb_wb_en_r <= mem_wb_en_r;
            wb_rd_r    <= mem_rd_r;
            if (exmem_bubble_s) begin
                mem_valid_r   <= 1'b0;
                mem_wb_en_r   <= 1'b0;
                mem_is_load_r <= 1'b0;
                mem_rd_r      <= REG_X0;
            end else begin
                mem_valid_r   <= ex_valid_r;
                mem_wb_en_r   <= ex_wb_en_r;
                mem_is_load_r <= ex_is_load_r;
                mem_rd_r      <= ex_rd_r;
            end
            if (ex_busy_s) begin
                ex_valid_r <= ex_valid_r;
            end else if (idex_flush_s | ~hif.id_valid) begin
                ex_valid_r    <= 1'b0;
                ex_wb_en_r    <= 1'b0;
                ex_is_load_r  <= 1'b0;
                ex_rd_r       <= REG_X0;
                ex_rs1_r      <= REG_X0;
                ex_rs2_r      <= REG_X0;
                ex_rs1_used_r <= 1'b0;
                ex_rs2_used_r <= 1'b0;
            end else begin
                ex_valid_r    <= 1'b1;
                ex_wb_en_r    <= hif.id_wb_en;
                ex_is_load_r  <= hif.id_is_load;
                ex_rd_r       <= hif.id_rd;
                ex_rs1_r      <= hif.id_rs1;
                ex_rs2_r      <= hif.id_rs2;
                ex_rs1_used_r <= hif.id_rs1_used;
                ex_rs2_used_r <= hif.id_rs2_used;
            end
        end
    end

    // MUL occupancy counter: loaded on MUL entry, counts down to release EX.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            mul_cnt_r <= CNT_ZERO;
        end else if (mul_enter_s) begin
            mul_cnt_r <= CNT_LOAD;
        end else if (ex_busy_s) begin
            mul_cnt_r <= mul_cnt_r - CNT_ONE;
        end else begin
            mul_cnt_r <= CNT_ZERO;
        end
    end

    assign hif.pc_en        = pc_en_s;
    assign hif.ifid_en      = ifid_en_s;
    assign hif.ifid_flush   = ifid_flush_s;
    assign hif.idex_en      = idex_en_s;
    assign hif.idex_flush   = idex_flush_s;
    assign hif.exmem_bubble = exmem_bubble_s;
    assign hif.fwd_a_sel    = fwd_a_s;
    assign hif.fwd_b_sel    = fwd_b_s;
    assign hif.ex_busy      = ex_busy_s;
endmodule

// File: tb/tb_hazard_ctrl.sv
// Bench for hazard_ctrl: an instruction-level pipeline model predicts the
// controller outputs each cycle; a scoreboard queue decouples the stimulus
// driver from the output monitor.
module tb_hazard_ctrl;
    localparam int REG_AW  = 5;
    localparam int MUL_LAT = 4;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    hazard_ctrl_if #(.REG_AW(REG_AW)) hif();
    hazard_ctrl #(.REG_AW(REG_AW), .MUL_LAT(MUL_LAT)) dut (
        .clk (clk),
        .rst (rst),
        .hif (hif)
    );

    typedef struct packed {
        logic v; logic [4:0] rd; logic [4:0] rs1; logic [4:0] rs2;
        logic u1; logic u2; logic wb; logic ld; logic mul; logic br;
    } instr_t;

    typedef struct packed {
        logic pc_en; logic ifid_en; logic ifid_flush; logic idex_en;
        logic idex_flush; logic exmem_bubble; logic [1:0] fa; logic [1:0] fb; logic busy;
    } exp_t;

    instr_t m_ex, m_mem, m_wb;   // instructions currently in EX/MEM/WB
    int     m_age;               // cycles the EX instruction has already spent in EX
    instr_t prog[$];
    exp_t   sb[$];
    int     checks = 0;
    int     failures = 0;
    int     cyc = 0;

    function automatic instr_t mk(logic ld, logic mul, logic [4:0] rd, logic wb,
                                  logic [4:0] rs1, logic u1, logic [4:0] rs2, logic u2, logic br);
        instr_t i;
        i.v = 1'b1; i.ld = ld; i.mul = mul; i.rd = rd; i.wb = wb;
        i.rs1 = rs1; i.u1 = u1; i.rs2 = rs2; i.u2 = u2; i.br = br;
        return i;
    endfunction

    function automatic instr_t rnd_instr();
        instr_t i;
        int k;
        k     = $urandom_range(0, 9);
        i.v   = ($urandom_range(0, 9) != 0);
        i.ld  = (k < 3);
        i.mul = (k == 3);
        i.rd  = 5'($urandom_range(0, 7));
        i.rs1 = 5'($urandom_range(0, 7));
        i.rs2 = 5'($urandom_range(0, 7));
        i.wb  = ($urandom_range(0, 4) != 0);
        i.u1  = ($urandom_range(0, 3) != 0);
        i.u2  = ($urandom_range(0, 3) != 0);
        i.br  = ($urandom_range(0, 9) == 0);
        return i;
    endfunction

    function automatic bit writes(instr_t s, logic [4:0] r);
        return s.v && s.wb && (s.rd != 5'd0) && (s.rd == r);
    endfunction

    function automatic bit m_busy();
        return m_ex.v && m_ex.mul && (m_age < MUL_LAT - 1);
    endfunction

    function automatic logic [1:0] src(logic used, logic [4:0] rs);
        if (!used) return 2'b00;
        if (writes(m_mem, rs)) return m_mem.ld ? 2'b00 : 2'b01;
        if (writes(m_wb, rs)) return 2'b10;
        return 2'b00;
    endfunction

    function automatic exp_t model_out(instr_t id, logic bt);
        exp_t e;
        bit busy, brk, lu;
        busy = m_busy();
        brk  = bt && m_ex.v && !busy;
        lu   = id.v && m_ex.ld && ((id.u1 && writes(m_ex, id.rs1)) || (id.u2 && writes(m_ex, id.rs2)));
        e = '0;
        if (busy) begin
            e.exmem_bubble = 1'b1;
        end else if (brk) begin
            e.pc_en = 1'b1; e.ifid_en = 1'b1; e.idex_en = 1'b1;
            e.ifid_flush = 1'b1; e.idex_flush = 1'b1;
        end else if (lu) begin
            e.idex_en = 1'b1; e.idex_flush = 1'b1;
        end else begin
            e.pc_en = 1'b1; e.ifid_en = 1'b1; e.idex_en = 1'b1;
        end
        e.fa   = src(m_ex.u1, m_ex.rs1);
        e.fb   = src(m_ex.u2, m_ex.rs2);
        e.busy = busy;
        return e;
    endfunction

    task automatic drive(instr_t i, logic bt);
        hif.id_valid        = i.v;
        hif.id_rd           = i.rd;
        hif.id_rs1          = i.rs1;
        hif.id_rs2          = i.rs2;
        hif.id_rs1_used     = i.u1;
        hif.id_rs2_used     = i.u2;
        hif.id_wb_en        = i.wb;
        hif.id_is_load      = i.ld;
        hif.id_is_mul       = i.mul;
        hif.ex_branch_taken = bt;
    endtask

    task automatic chk(string name, logic [1:0] act, logic [1:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s cycle=%0d actual=%0h required=%0h", name, cyc, act, req);
        end
    endtask

    // Monitor: every cycle the DUT presents outputs; compare against the oldest prediction.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            #2;
            if (sb.size() > 0) begin
                e = sb.pop_front();
                chk("pc_en",        {1'b0, hif.pc_en},        {1'b0, e.pc_en});
                chk("ifid_en",      {1'b0, hif.ifid_en},      {1'b0, e.ifid_en});
                chk("ifid_flush",   {1'b0, hif.ifid_flush},   {1'b0, e.ifid_flush});
                chk("idex_en",      {1'b0, hif.idex_en},      {1'b0, e.idex_en});
                chk("idex_flush",   {1'b0, hif.idex_flush},   {1'b0, e.idex_flush});
                chk("exmem_bubble", {1'b0, hif.exmem_bubble}, {1'b0, e.exmem_bubble});
                chk("fwd_a_sel",    hif.fwd_a_sel,            e.fa);
                chk("fwd_b_sel",    hif.fwd_b_sel,            e.fb);
                chk("ex_busy",      {1'b0, hif.ex_busy},      {1'b0, e.busy});
            end
        end
    end

    // Watchdog: the run must end on its own.
    initial begin
        #2000000;
        $display("FAIL watchdog cycle=%0d actual=running required=finished", cyc);
        $fatal(1, "watchdog expired");
    end

    // Driver: feeds ID from the program, honouring the predicted IF/ID enable/flush.
    initial begin
        instr_t cur, nop;
        exp_t   e;
        logic   bt;
        bit     rst_req;
        nop = '0;
        cur = nop;
        m_ex = nop; m_mem = nop; m_wb = nop; m_age = 0;
        rst = 1'b0;
        drive(nop, 1'b0);

        // Power-on reset: outputs must show reset values while held.
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            cyc++;
            drive(rnd_instr(), 1'b1);
            sb.push_back(model_out(nop, 1'b0));
        end

        // Directed program (ld, mul, rd, wb, rs1, u1, rs2, u2, br)
        prog.push_back(mk(1'b1, 1'b0, 5'd5, 1'b1, 5'd1, 1'b1, 5'd0, 1'b0, 1'b0)); // lw x5
        prog.push_back(mk(1'b0, 1'b0, 5'd6, 1'b1, 5'd5, 1'b1, 5'd1, 1'b1, 1'b0)); // add x6,x5,x1
        for (int i = 0; i < 3; i++) prog.push_back(nop);
        prog.push_back(mk(1'b0, 1'b0, 5'd5, 1'b1, 5'd1, 1'b1, 5'd2, 1'b1, 1'b0)); // add x5
        prog.push_back(mk(1'b0, 1'b0, 5'd7, 1'b1, 5'd1, 1'b1, 5'd5, 1'b1, 1'b0)); // sub x7,x1,x5
        prog.push_back(mk(1'b0, 1'b0, 5'd5, 1'b1, 5'd1, 1'b1, 5'd2, 1'b1, 1'b0)); // add x5
        prog.push_back(nop);
        prog.push_back(mk(1'b0, 1'b0, 5'd7, 1'b1, 5'd1, 1'b1, 5'd5, 1'b1, 1'b0)); // sub x7,x1,x5
        for (int i = 0; i < 3; i++) prog.push_back(nop);
        prog.push_back(mk(1'b1, 1'b0, 5'd0, 1'b1, 5'd1, 1'b1, 5'd0, 1'b0, 1'b0)); // lw x0
        prog.push_back(mk(1'b0, 1'b0, 5'd6, 1'b1, 5'd0, 1'b1, 5'd0, 1'b1, 1'b0)); // add x6,x0,x0
        for (int i = 0; i < 3; i++) prog.push_back(nop);
        prog.push_back(mk(1'b0, 1'b0, 5'd5, 1'b1, 5'd1, 1'b1, 5'd2, 1'b1, 1'b0)); // add x5
        prog.push_back(mk(1'b0, 1'b0, 5'd5, 1'b1, 5'd3, 1'b1, 5'd4, 1'b1, 1'b0)); // add x5
        prog.push_back(mk(1'b0, 1'b0, 5'd8, 1'b1, 5'd5, 1'b1, 5'd5, 1'b1, 1'b0)); // add x8,x5,x5
        for (int i = 0; i < 3; i++) prog.push_back(nop);
        prog.push_back(mk(1'b0, 1'b1, 5'd5, 1'b1, 5'd1, 1'b1, 5'd2, 1'b1, 1'b0)); // mul x5
        prog.push_back(mk(1'b0, 1'b0, 5'd9, 1'b1, 5'd5, 1'b1, 5'd1, 1'b1, 1'b0)); // add x9,x5,x1
        for (int i = 0; i < 3; i++) prog.push_back(nop);
        prog.push_back(mk(1'b1, 1'b0, 5'd5, 1'b1, 5'd1, 1'b1, 5'd0, 1'b0, 1'b1)); // lw x5, branch resolves taken
        prog.push_back(mk(1'b0, 1'b0, 5'd6, 1'b1, 5'd5, 1'b1, 5'd1, 1'b1, 1'b0)); // add x6,x5,x1
        for (int i = 0; i < 3; i++) prog.push_back(nop);
        prog.push_back(mk(1'b0, 1'b1, 5'd10, 1'b1, 5'd1, 1'b1, 5'd2, 1'b1, 1'b0)); // mul x10: reset hits it
        prog.push_back(mk(1'b0, 1'b0, 5'd11, 1'b1, 5'd10, 1'b1, 5'd1, 1'b1, 1'b0));
        for (int i = 0; i < 1500; i++) prog.push_back(rnd_instr());
        rst_req = 1'b1;

        while ((prog.size() > 0 || cur.v) && cyc < 20000) begin
            @(negedge clk);
            cyc++;
            rst = 1'b1;
            if (rst_req && m_ex.v && m_ex.mul && m_ex.rd == 5'd10 && m_age == 1) begin
                // Reset during the second busy MUL cycle; held across one rising edge.
                rst = 1'b0;
                rst_req = 1'b0;
                m_ex = nop; m_mem = nop; m_wb = nop; m_age = 0;
                drive(cur, 1'b1);
                sb.push_back(model_out(cur, 1'b0));
                cur = nop;
            end else begin
                bt = m_ex.br | ((!m_ex.v || m_busy()) && ($urandom_range(0, 3) == 0));
                drive(cur, bt);
                e = model_out(cur, bt);
                sb.push_back(e);
                m_wb  = m_mem;
                m_mem = e.exmem_bubble ? nop : m_ex;
                if (e.busy) begin
                    m_age++;
                end else if (e.idex_flush || !cur.v) begin
                    m_ex = nop; m_age = 0;
                end else begin
                    m_ex = cur; m_age = 0;
                end
                if (e.ifid_flush) cur = nop;
                else if (e.ifid_en) cur = (prog.size() > 0) ? prog.pop_front() : nop;
            end
        end

        rst = 1'b1;
        drive(nop, 1'b0);
        @(negedge clk);
        #5;
        checks++;
        if (prog.size() != 0 || sb.size() != 0) begin
            failures++;
            $display("FAIL drain cycle=%0d actual=prog%0d_sb%0d required=prog0_sb0", cyc, prog.size(), sb.size());
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
